// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Holds the default counter width, the minimum legal period, the period
// clamp helper and the packed duty-array type for the default geometry.
package pwm_pkg;

    localparam int CNT_W_DEF  = 28;
    localparam int N_CH_DEF   = 4;
    localparam int PERIOD_MIN = 2;

    // One duty word per channel, channel 0 in the least significant slot.
    typedef logic [N_CH_DEF-1:0][CNT_W_DEF-1:0] duty_arr_t;

    // A period below the minimum would leave no room for a low phase,
    // so it is raised to the minimum instead.
    function automatic logic [31:0] clamp_period(input logic [31:0] p);
        if (p < 32'(PERIOD_MIN)) begin
            return 32'(PERIOD_MIN);
        end else begin
            return p;
        end
    endfunction

endpackage

// File: rtl/pwm_gen_multi_chan.sv
// One PWM channel: owns its active duty word and the registered compare.
// Ports:
//   clk_in, rst  - clock and synchronous active-high reset
//   en_i         - run enable; low forces the output low next cycle
//   apply_i      - load duty_stg_i into the active duty this cycle
//   cnt_i        - shared period counter
//   duty_stg_i   - staged duty for this channel
//   pwm_o        - registered PWM output
module pwm_chan #(
    parameter int CNT_W    = 28,
    parameter int RST_DUTY = 303
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en_i,
    input  logic             apply_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_stg_i,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] RST_DUTY_C = CNT_W'(RST_DUTY);

    logic [CNT_W-1:0] act_duty_q, act_duty_d;
    logic             pwm_q, pwm_d;

    // Next-state: duty swaps only on apply; compare against the duty that
    // is active in this cycle so a swap takes effect from the next cnt.
    always_comb begin
        act_duty_d = act_duty_q;
        if (apply_i) begin
            act_duty_d = duty_stg_i;
        end else begin
            act_duty_d = act_duty_q;
        end
        pwm_d = en_i && (cnt_i < act_duty_q);
    end

    // Channel state registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            act_duty_q <= RST_DUTY_C;
            pwm_q      <= 1'b0;
        end else begin
            act_duty_q <= act_duty_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator with a shared period counter.
// New period/duty settings are staged by cfg_wr and applied together at
// the next period boundary (or immediately while disabled), so a running
// waveform never sees a partial period.
// Ports:
//   clk_in, rst     - clock and synchronous active-high reset
//   en              - run enable; low holds cnt at 0 and drives outputs low
//   cfg_wr          - strobe latching period_i/duty_i into staging
//   period_i        - requested period (values below 2 become 2)
//   duty_i          - requested high time, CNT_W bits per channel
//   cfg_pending_o   - staged config not yet applied
//   pwm_o           - registered PWM outputs
//   period_start_o  - one-cycle pulse on the first output cycle of a period
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int N_CH       = 4,
    parameter int RST_PERIOD = 606,
    parameter int RST_DUTY   = RST_PERIOD / 2
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    cfg_wr,
    input  logic [CNT_W-1:0]        period_i,
    input  logic [N_CH*CNT_W-1:0]   duty_i,
    output logic                    cfg_pending_o,
    output logic [N_CH-1:0]         pwm_o,
    output logic                    period_start_o
);

    localparam logic [CNT_W-1:0] ZERO_C       = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_PERIOD_C = CNT_W'(clamp_period(32'(RST_PERIOD)));
    localparam logic [CNT_W-1:0] RST_DUTY_C   = CNT_W'(RST_DUTY);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      act_period_q, act_period_d;
    logic [CNT_W-1:0]      stg_period_q, stg_period_d;
    logic [N_CH*CNT_W-1:0] stg_duty_q, stg_duty_d;
    logic                  pending_q, pending_d;
    logic                  pstart_q, pstart_d;
    logic                  boundary_s;
    logic                  apply_s;
    logic [CNT_W-1:0]      period_wr_s;

    // Next-state for counter, staging and pending flag.
    always_comb begin
        period_wr_s = CNT_W'(clamp_period(32'(period_i)));
        boundary_s  = en && (cnt_q == (act_period_q - ONE_C));
        // Apply looks only at pending from the start of the cycle, so a
        // cfg_wr landing on a boundary waits for the following one.
        apply_s     = pending_q && (boundary_s || !en);

        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = ZERO_C;
        end else if (boundary_s) begin
            cnt_d = ZERO_C;
        end else begin
            cnt_d = cnt_q + ONE_C;
        end

        act_period_d = act_period_q;
        if (apply_s) begin
            act_period_d = stg_period_q;
        end else begin
            act_period_d = act_period_q;
        end

        stg_period_d = stg_period_q;
        stg_duty_d   = stg_duty_q;
        pending_d    = pending_q;
        if (cfg_wr) begin
            stg_period_d = period_wr_s;
            stg_duty_d   = duty_i;
            pending_d    = 1'b1;
        end else if (apply_s) begin
            pending_d    = 1'b0;
        end else begin
            pending_d    = pending_q;
        end

        pstart_d = en && (cnt_q == ZERO_C);
    end

    // Shared counter, staging and status registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q        <= ZERO_C;
            act_period_q <= RST_PERIOD_C;
            stg_period_q <= RST_PERIOD_C;
            stg_duty_q   <= {N_CH{RST_DUTY_C}};
            pending_q    <= 1'b0;
            pstart_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            stg_period_q <= stg_period_d;
            stg_duty_q   <= stg_duty_d;
            pending_q    <= pending_d;
            pstart_q     <= pstart_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        pwm_chan #(
            .CNT_W    (CNT_W),
            .RST_DUTY (RST_DUTY)
        ) u_chan (
            .clk_in     (clk_in),
            .rst        (rst),
            .en_i       (en),
            .apply_i    (apply_s),
            .cnt_i      (cnt_q),
            .duty_stg_i (stg_duty_q[g*CNT_W +: CNT_W]),
            .pwm_o      (pwm_o[g])
        );
    end

    assign cfg_pending_o  = pending_q;
    assign period_start_o = pstart_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
module tb_pwm_gen_multi;

    localparam int CNT_W = 8;
    localparam int N_CH  = 2;

    logic                  clk_in = 1'b0;
    logic                  rst    = 1'b1;
    logic                  en     = 1'b0;
    logic                  cfg_wr = 1'b0;
    logic [CNT_W-1:0]      period_i = 8'd0;
    logic [N_CH*CNT_W-1:0] duty_i   = 16'd0;
    logic                  cfg_pending_o;
    logic [N_CH-1:0]       pwm_o;
    logic                  period_start_o;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_gen_multi #(
        .CNT_W      (CNT_W),
        .N_CH       (N_CH),
        .RST_PERIOD (10),
        .RST_DUTY   (5)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .en             (en),
        .cfg_wr         (cfg_wr),
        .period_i       (period_i),
        .duty_i         (duty_i),
        .cfg_pending_o  (cfg_pending_o),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: position within the current period plus the
    // active and waiting settings, and the outputs expected after the edge.
    int         m_pos = 0;
    int         m_per = 10;
    int         m_duty [N_CH] = '{5, 5};
    int         s_per = 10;
    int         s_duty [N_CH] = '{5, 5};
    bit         m_pend = 1'b0;
    logic [1:0] exp_pwm = 2'b00;
    logic       exp_ps = 1'b0;
    logic       exp_pend = 1'b0;

    task automatic model_tick();
        bit at_end;
        bit do_apply;
        if (rst) begin
            m_pos = 0; m_per = 10; s_per = 10; m_pend = 1'b0;
            for (int i = 0; i < N_CH; i++) begin m_duty[i] = 5; s_duty[i] = 5; end
            exp_pwm = 2'b00; exp_ps = 1'b0; exp_pend = 1'b0;
        end else begin
            at_end = en && (m_pos == m_per - 1);
            for (int i = 0; i < N_CH; i++) exp_pwm[i] = en && (m_pos < m_duty[i]);
            exp_ps   = en && (m_pos == 0);
            do_apply = m_pend && (at_end || !en);
            m_pos    = (!en || at_end) ? 0 : m_pos + 1;
            if (do_apply) begin
                m_per = s_per;
                for (int i = 0; i < N_CH; i++) m_duty[i] = s_duty[i];
            end
            if (cfg_wr) begin
                s_per = (int'(period_i) < 2) ? 2 : int'(period_i);
                for (int i = 0; i < N_CH; i++) s_duty[i] = int'(duty_i[i*CNT_W +: CNT_W]);
                m_pend = 1'b1;
            end else if (do_apply) begin
                m_pend = 1'b0;
            end
            exp_pend = m_pend;
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cfg_wr = 1'b0;
        step(); step();
        n_checks++;
        if (pwm_o !== 2'b00) begin n_fail++; $display("FAIL reset_pwm got %b want 00", pwm_o); end
        n_checks++;
        if (period_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_ps got %b want 0", period_start_o); end
        n_checks++;
        if (cfg_pending_o !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b want 0", cfg_pending_o); end
        rst = 1'b0; en = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int hi0 = 0, hi1 = 0, ps = 0;
        en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 0) begin
                n_checks++;
                if (period_start_o !== 1'b1) begin n_fail++; $display("FAIL basic_first_ps got %b want 1", period_start_o); end
            end
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps) begin
                n_fail++; $display("FAIL basic_wave c=%0d got %b/%b want %b/%b", c, pwm_o, period_start_o, exp_pwm, exp_ps);
            end
            hi0 += int'(pwm_o[0]); hi1 += int'(pwm_o[1]); ps += int'(period_start_o);
        end
        n_checks++;
        if (hi0 != 10 || hi1 != 10 || ps != 2) begin
            n_fail++; $display("FAIL basic_counts got %0d/%0d/%0d want 10/10/2", hi0, hi1, ps);
        end
    endtask

    task automatic test_cfg_mid();
        step(); step(); step();
        cfg_wr = 1'b1; period_i = 8'd4; duty_i = {8'd3, 8'd1};
        step();
        cfg_wr = 1'b0;
        n_checks++;
        if (cfg_pending_o !== 1'b1) begin n_fail++; $display("FAIL mid_pend_set got %b want 1", cfg_pending_o); end
        for (int c = 0; c < 24; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps || cfg_pending_o !== exp_pend) begin
                n_fail++; $display("FAIL mid_wave c=%0d got %b/%b/%b want %b/%b/%b", c, pwm_o,
                                   period_start_o, cfg_pending_o, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    task automatic test_const();
        cfg_wr = 1'b1; period_i = 8'd4; duty_i = {8'd6, 8'd0};
        step();
        cfg_wr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || cfg_pending_o !== exp_pend) begin
                n_fail++; $display("FAIL const_apply c=%0d got %b/%b want %b/%b", c, pwm_o, cfg_pending_o, exp_pwm, exp_pend);
            end
        end
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (pwm_o !== 2'b10) begin n_fail++; $display("FAIL const_level c=%0d got %b want 10", c, pwm_o); end
        end
    endtask

    task automatic test_min_period();
        int hi = 0, ps = 0;
        cfg_wr = 1'b1; period_i = 8'd1; duty_i = {8'd1, 8'd1};
        step();
        cfg_wr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps) begin
                n_fail++; $display("FAIL minper_apply c=%0d got %b/%b want %b/%b", c, pwm_o, period_start_o, exp_pwm, exp_ps);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step();
            hi += int'(pwm_o[0]); ps += int'(period_start_o);
        end
        n_checks++;
        if (hi != 4 || ps != 4) begin n_fail++; $display("FAIL minper_counts got %0d/%0d want 4/4", hi, ps); end
    endtask

    task automatic test_back_to_back();
        cfg_wr = 1'b1; period_i = 8'd5; duty_i = {8'd2, 8'd3};
        step();
        cfg_wr = 1'b0;
        for (int c = 0; c < 10 && m_pos != m_per - 1; c++) step();
        // Write lands exactly on the boundary cycle.
        cfg_wr = 1'b1; period_i = 8'd3; duty_i = {8'd1, 8'd2};
        step();
        cfg_wr = 1'b0;
        n_checks++;
        if (cfg_pending_o !== 1'b1) begin n_fail++; $display("FAIL bnd_pend_kept got %b want 1", cfg_pending_o); end
        for (int c = 0; c < 16; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps || cfg_pending_o !== exp_pend) begin
                n_fail++; $display("FAIL bnd_wave c=%0d got %b/%b/%b want %b/%b/%b", c, pwm_o,
                                   period_start_o, cfg_pending_o, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    task automatic test_en_drop();
        cfg_wr = 1'b1; period_i = 8'd6; duty_i = {8'd4, 8'd5};
        step();
        cfg_wr = 1'b0;
        repeat (10) step();
        en = 1'b0;
        step();
        n_checks++;
        if (pwm_o !== 2'b00 || period_start_o !== 1'b0) begin
            n_fail++; $display("FAIL endrop got %b/%b want 00/0", pwm_o, period_start_o);
        end
        step();
        en = 1'b1;
        step();
        n_checks++;
        if (period_start_o !== 1'b1 || pwm_o !== 2'b11) begin
            n_fail++; $display("FAIL reen got %b/%b want 11/1", pwm_o, period_start_o);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps) begin
                n_fail++; $display("FAIL reen_wave c=%0d got %b/%b want %b/%b", c, pwm_o, period_start_o, exp_pwm, exp_ps);
            end
        end
    endtask

    task automatic test_rst_pending();
        cfg_wr = 1'b1; period_i = 8'd3; duty_i = {8'd1, 8'd1};
        step();
        cfg_wr = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if (pwm_o !== 2'b00 || period_start_o !== 1'b0 || cfg_pending_o !== 1'b0) begin
            n_fail++; $display("FAIL rstpend got %b/%b/%b want 00/0/0", pwm_o, period_start_o, cfg_pending_o);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps || cfg_pending_o !== exp_pend) begin
                n_fail++; $display("FAIL rstpend_wave c=%0d got %b/%b/%b want %b/%b/%b", c, pwm_o,
                                   period_start_o, cfg_pending_o, exp_pwm, exp_ps, exp_pend);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en       = ($urandom_range(9, 0) != 0);
            cfg_wr   = ($urandom_range(7, 0) == 0);
            period_i = 8'($urandom_range(12, 0));
            duty_i   = {8'($urandom_range(14, 0)), 8'($urandom_range(14, 0))};
            step();
            n_checks++;
            if (pwm_o !== exp_pwm || period_start_o !== exp_ps || cfg_pending_o !== exp_pend) begin
                n_fail++; $display("FAIL rand c=%0d got %b/%b/%b want %b/%b/%b", c, pwm_o,
                                   period_start_o, cfg_pending_o, exp_pwm, exp_ps, exp_pend);
            end
        end
        cfg_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cfg_mid();
        test_const();
        test_min_period();
        test_back_to_back();
        test_en_drop();
        test_rst_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Multi-channel PWM generator for the PWM subsystem. It is the parametrised successor to the fixed single-output 50 % clock divider. One shared period counter drives N_CH independent duty comparators. Period and duties are programmable at run time through staging registers, and new settings are applied glitch-free at the next period boundary. It feeds motor/LED drivers directly and gives downstream logic a per-period strobe.

## Interface
- CNT_W, 28: counter, period and duty width in bits.
- N_CH, 4: number of PWM output channels (1..16).
- RST_PERIOD, 606: active period after reset, in clk_in cycles.
- RST_DUTY, RST_PERIOD/2: active duty of every channel after reset.
- clk_in  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; low holds the counter and forces outputs low.
- cfg_wr  in  1  one-cycle strobe; latches period_i and duty_i into the staging registers.
- period_i  in  CNT_W  requested period in cycles.
- duty_i  in  N_CH×CNT_W  requested high-time per channel, in cycles.
- cfg_pending_o  out  1  high while staged config has not yet been applied.
- pwm_o  out  N_CH  PWM outputs, registered.
- period_start_o  out  1  one-cycle pulse aligned with the first output cycle of each period.

## Operation
- Reset values:
  - cnt = 0; active period = RST_PERIOD; all active duties = RST_DUTY.
  - Staging registers = the active values.
  - pwm_o = 0, period_start_o = 0, cfg_pending_o = 0.
- Period clamp: a period value below 2 is stored as 2. Width is CNT_W, unsigned, with no other wrap handling.
- Counting with en = 1:
  - cnt runs 0 .. act_period-1, then returns to 0.
  - The cycle where cnt == act_period-1 is the boundary.
- Channel output: pwm_o[i] next = en && (cnt < act_duty[i]).
  - Duty 0 gives constant low.
  - Duty >= act_period gives constant high, with no glitch at the wrap.
- cfg_wr:
  - Writes staging regardless of en.
  - Sets cfg_pending_o on the next cycle.
  - A second cfg_wr before the apply overwrites staging; last write wins.
- Apply:
  - Happens on a boundary cycle with en = 1, or on any cycle with en = 0, when pending = 1 at the start of that cycle.
  - Copies staging to active and clears pending.
  - If cfg_wr coincides with a boundary, the new write is not applied at that boundary. Pending stays 1 and it applies at the next boundary.
- en = 0:
  - cnt is forced to 0 and pwm_o goes to 0 the next cycle.
  - period_start_o = 0.
- en 0→1: counting starts at cnt = 0, and period_start_o pulses on the first output cycle.
- rst has priority over everything, including a pending config and en; the pending config is discarded.

## Timing
- Outputs are registered: pwm_o and period_start_o in cycle t+1 reflect cnt in cycle t. Latency from en rise to the first pwm_o high is 1 cycle.
- period_start_o is high exactly when the registered outputs reflect cnt == 0, once per period, and is never wider than one cycle.
- A config applied on boundary cycle t uses the new period and duties from cnt = 0 in cycle t+1; outputs change at t+2.
- cfg_pending_o falls in the cycle after the apply.
- There is no stall or ready: cfg_wr is always accepted.

## Structure
- Package pwm_pkg holds:
  - the default CNT_W;
  - the period minimum constant (2);
  - a clamp function for period;
  - typedef duty_arr_t (N_CH×CNT_W).
- Sub-module pwm_chan: one per channel.
  - Holds that channel's active duty register and its registered compare output.
  - Driven by shared cnt, en and the apply strobe.
- Top level holds the counter, staging registers, pending flag and apply logic.

## Test plan
Bench parameters: CNT_W = 8, N_CH = 2, RST_PERIOD = 10, RST_DUTY = 5.
- Reset, then en = 1 → each pwm_o is 5 high / 5 low, and period_start_o pulses every 10 cycles, starting 1 cycle after en.
- cfg_wr mid-period with period = 4, duty = {1,3} → cfg_pending_o = 1 until the boundary. Afterwards pwm_o[0] is 1/4 high, pwm_o[1] is 3/4 high, and period_start_o comes every 4 cycles with no partial period.
- Period 4 with duty = {0,6} → pwm_o[0] is constant 0 and pwm_o[1] is constant 1 across several wraps.
- cfg_wr with period = 1 → the active period becomes 2; duty 1 gives 1 high / 1 low.
- cfg_wr on the boundary cycle → the old config runs one more period, then the new one applies.
- Drop en mid-period → pwm_o = 0 the next cycle. Re-enable → restart at cnt 0 with a period_start_o pulse.
- rst mid-run while pending = 1 → all outputs at reset values, and the RST_PERIOD/RST_DUTY waveform resumes afterwards.
